wb_arb2: RTL and testbench
==========================

# wb_arb2

Two-master Wishbone arbiter that shares one 16-bit register-block slave bus (e.g. a `parreg16` bank) between a host interface and an internal sequencer. Grants are round-robin and held for the whole `cyc` burst, with the slave signals muxed from the owning master. A per-grant watchdog aborts transactions the slave never acknowledges and returns `err` to the stalled master. Sits between the master ports and the register decoder in the channel FPGA.

## Interface
- `ADRBITS`, 1: slave address width, passed through unchanged.
- `TMOBITS`, 4: watchdog width; abort after 2**TMOBITS consecutive wait cycles.

Ports:
- `wb_clk`  in  1  system clock; all logic on its rising edge.
- `wb_rst_n`  in  1  asynchronous, active-low reset.
- `m0_cyc`, `m0_stb`, `m0_we`  in  1 each  master 0 strobes.
- `m0_adr`  in  ADRBITS  master 0 address.
- `m0_dat_i`  in  16  master 0 write data.
- `m0_dat_o`  out  16  read data to master 0.
- `m0_ack`, `m0_err`  out  1 each  master 0 termination.
- `m1_*`  same set as `m0_*`, for master 1.
- `s_cyc`, `s_stb`, `s_we`  out  1 each  slave strobes.
- `s_adr`  out  ADRBITS  slave address.
- `s_dat_o`  out  16  slave write data.
- `s_dat_i`  in  16  slave read data.
- `s_ack`  in  1  slave acknowledge.
- `gnt`  out  2  one-hot current owner (bit0 = m0); 00 when idle.

## Operation
- FSM states: IDLE, GNT0, GNT1, ABORT0, ABORT1. The state and `last` (last-served master) registers are the only arbitration state.
- IDLE:
  - A request is `mX_cyc & mX_stb`.
  - With one requester, grant it (GNTx).
  - With both requesting, grant the master != `last`.
  - `last` resets to 1, so m0 wins the first contention.
- GNTx, bus routing:
  - `s_cyc/s_stb/s_we/s_adr/s_dat_o` are driven combinationally from master x.
  - `mx_ack = s_ack`; the other master's ack/err stay 0.
- GNTx, exits:
  - If `mx_cyc` is low, go to IDLE and set `last <= x`.
  - A held `cyc` keeps ownership across multiple `stb` phases.
- Watchdog:
  - Counter `cnt` (TMOBITS bits) clears on entry to GNTx, on `s_ack`, and on any cycle with `mx_stb` low.
  - It increments on each GNTx cycle with `mx_stb & !s_ack`.
  - When `cnt` is all-ones in such a cycle, the next state is ABORTx.
- ABORTx:
  - All `s_*` outputs are 0.
  - `mx_err = mx_stb`; `mx_ack = 0`.
  - Leave to IDLE when `mx_cyc` is low, and set `last <= x`.
- Read data: `m0_dat_o = m1_dat_o = s_dat_i`, broadcast. Valid only while that master's `ack` is high.
- Idle outputs: `s_cyc`, `s_stb`, `s_we` = 0; `s_adr`, `s_dat_o` = 0; `gnt` = 00.

## Timing
- Reset (`wb_rst_n` low, takes effect asynchronously):
  - state IDLE, `last = 1`, `cnt = 0`.
  - All outputs 0: `gnt = 00`, `s_*` = 0, `mX_ack` = 0, `mX_err` = 0.
- Grant latency:
  - Request sampled in cycle n gives `gnt` and `s_cyc/s_stb` in cycle n+1.
  - A registered-ack slave (ack one cycle after `cyc&stb`) gives `mx_ack` in n+2.
- Release:
  - `mx_cyc` low in cycle k gives IDLE in k+1.
  - A pending other master is granted in k+2, so there is always one idle bubble between owners.
- Boundary conditions:
  - `s_ack` and watchdog terminal count in the same cycle: ack wins; no abort, and `cnt` clears.
  - `s_ack` arriving while in ABORTx is ignored.
  - Requester drops `stb` but keeps `cyc`: the grant is held and the watchdog is frozen at 0.
  - Reset asserted mid-transaction: `s_cyc` drops and all acks/errs drop immediately, without waiting for a clock edge.
  - `s_ack` while IDLE is ignored.

## Structure
- Shared header `wb_arb_defs.vh`: state encodings (ST_IDLE, ST_GNT0, ST_GNT1, ST_ABORT0, ST_ABORT1).
- Natural sub-module `wb_arb_tmo`: watchdog counter with ports clk, async reset, clear, count enable and terminal-count output; parameter TMOBITS.
- The output mux and FSM stay in `wb_arb2`.

## Test plan
- Single master write: m0 writes 16'hA5C3 to adr 0 with a registered-ack slave.
  - `gnt = 01` one cycle after the request.
  - Slave sees `s_we = 1`, `s_dat_o = A5C3`.
  - `m0_ack` two cycles after the request; `m1_ack` stays 0.
- Simultaneous requests from reset: m0 wins first.
  - After m0 drops `cyc`: one idle cycle, then `gnt = 10`.
  - Next simultaneous request goes to m0 again, since `last = 1`.
- Held burst: m1 holds `cyc` and issues 3 reads while m0 requests.
  - m0 is not granted until m1 drops `cyc`.
  - Each of m1's reads returns the slave data with `m1_ack`.
- Timeout, with TMOBITS = 4 and a slave that never acks:
  - m0 `stb` is high from grant cycle g.
  - `s_cyc` drops at g+16 and `m0_err = 1` at g+16.
  - After m0 drops `cyc`: IDLE, and m1 can be granted.
- Ack on the terminal-count cycle: the slave acks on the 16th wait cycle.
  - `m0_ack = 1`, `m0_err` never asserts, and the FSM stays in GNT0.
- Reset mid-write: `wb_rst_n` pulsed low during GNT1.
  - `s_cyc`, `gnt` and `m1_ack` go to 0 before the next clock edge.
  - After release, m0 wins contention.

Source files
------------

// File: rtl/wb_arb2_pkg.sv
// rtl/wb_arb2_pkg.sv - shared types and constants for the two-master Wishbone arbiter
//
// Purpose: arbitration state encoding and data-path width shared by wb_arb2
// and its bench.
package wb_arb2_pkg;

    localparam int DATBITS = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GNT0   = 3'd1,
        ST_GNT1   = 3'd2,
        ST_ABORT0 = 3'd3,
        ST_ABORT1 = 3'd4
    } arb_state_t;

endpackage

// File: rtl/wb_arb_tmo.sv
// rtl/wb_arb_tmo.sv - per-grant watchdog counter for the Wishbone arbiter
//
// Purpose: counts consecutive slave wait cycles of the owning master.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   clr    - synchronous clear (takes priority over en)
//   en     - count one wait cycle
//   tc     - terminal count: counter is all-ones
module wb_arb_tmo
    import wb_arb2_pkg::*;
#(
    parameter int TMOBITS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [TMOBITS-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + {{(TMOBITS-1){1'b0}}, 1'b1};
        end
    end

    assign tc = &cnt;

endmodule

// File: rtl/wb_arb2.sv
// rtl/wb_arb2.sv - two-master round-robin Wishbone arbiter with abort watchdog
//
// Purpose: shares one 16-bit Wishbone slave between two masters. Ownership is
// granted round-robin and held for the whole cyc burst; a watchdog aborts a
// transfer the slave never acknowledges and returns err to the stalled master.
// Ports:
//   wb_clk, wb_rst_n           - clock, asynchronous active-low reset
//   m0_* / m1_*                - master ports (cyc, stb, we, adr, dat_i in;
//                                dat_o, ack, err out)
//   s_cyc, s_stb, s_we, s_adr,
//   s_dat_o                    - slave request, muxed from the owning master
//   s_dat_i, s_ack             - slave read data and acknowledge
//   gnt                        - one-hot owner (bit0 = m0), 00 when idle
module wb_arb2
    import wb_arb2_pkg::*;
#(
    parameter int ADRBITS = 1,
    parameter int TMOBITS = 4
) (
    input  logic               wb_clk,
    input  logic               wb_rst_n,
    input  logic               m0_cyc,
    input  logic               m0_stb,
    input  logic               m0_we,
    input  logic [ADRBITS-1:0] m0_adr,
    input  logic [DATBITS-1:0] m0_dat_i,
    output logic [DATBITS-1:0] m0_dat_o,
    output logic               m0_ack,
    output logic               m0_err,
    input  logic               m1_cyc,
    input  logic               m1_stb,
    input  logic               m1_we,
    input  logic [ADRBITS-1:0] m1_adr,
    input  logic [DATBITS-1:0] m1_dat_i,
    output logic [DATBITS-1:0] m1_dat_o,
    output logic               m1_ack,
    output logic               m1_err,
    output logic               s_cyc,
    output logic               s_stb,
    output logic               s_we,
    output logic [ADRBITS-1:0] s_adr,
    output logic [DATBITS-1:0] s_dat_o,
    input  logic [DATBITS-1:0] s_dat_i,
    input  logic               s_ack,
    output logic [1:0]         gnt
);

    arb_state_t state, state_nxt;
    logic       last, last_nxt;
    logic       req0, req1;
    logic       sel;
    logic       own_cyc, own_stb, own_we;
    logic [ADRBITS-1:0] own_adr;
    logic [DATBITS-1:0] own_dat;
    logic       tmo_clr, tmo_en, tmo_tc;

    assign req0 = m0_cyc & m0_stb;
    assign req1 = m1_cyc & m1_stb;

    // Owner select: the same master mux serves both the grant and abort states.
    assign sel     = (state == ST_GNT1) || (state == ST_ABORT1);
    assign own_cyc = sel ? m1_cyc   : m0_cyc;
    assign own_stb = sel ? m1_stb   : m0_stb;
    assign own_we  = sel ? m1_we    : m0_we;
    assign own_adr = sel ? m1_adr   : m0_adr;
    assign own_dat = sel ? m1_dat_i : m0_dat_i;

    // Read data is broadcast; each master qualifies it with its own ack.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    wb_arb_tmo #(
        .TMOBITS(TMOBITS)
    ) u_tmo (
        .clk  (wb_clk),
        .rst_n(wb_rst_n),
        .clr  (tmo_clr),
        .en   (tmo_en),
        .tc   (tmo_tc)
    );

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state <= ST_IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    // All outputs decode from the state register, so an asynchronous reset
    // drops them without waiting for a clock edge.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        gnt       = 2'b00;
        s_cyc     = 1'b0;
        s_stb     = 1'b0;
        s_we      = 1'b0;
        s_adr     = '0;
        s_dat_o   = '0;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        m0_err    = 1'b0;
        m1_err    = 1'b0;
        tmo_clr   = 1'b1;
        tmo_en    = 1'b0;

        case (state)
            ST_IDLE: begin
                // On contention the master that was not served last wins.
                if (req0 && (!req1 || last)) begin
                    state_nxt = ST_GNT0;
                end else if (req1) begin
                    state_nxt = ST_GNT1;
                end
            end

            ST_GNT0, ST_GNT1: begin
                gnt     = sel ? 2'b10 : 2'b01;
                s_cyc   = own_cyc;
                s_stb   = own_stb;
                s_we    = own_we;
                s_adr   = own_adr;
                s_dat_o = own_dat;
                m0_ack  = !sel & s_ack;
                m1_ack  = sel & s_ack;
                // The watchdog only runs while a strobe waits for an ack.
                tmo_clr = !own_stb | s_ack;
                tmo_en  = own_stb & !s_ack;
                if (!own_cyc) begin
                    state_nxt = ST_IDLE;
                    last_nxt  = sel;
                end else if (own_stb && !s_ack && tmo_tc) begin
                    state_nxt = sel ? ST_ABORT1 : ST_ABORT0;
                end
            end

            ST_ABORT0, ST_ABORT1: begin
                // Slave is cut off; the stalled master sees err until it ends cyc.
                gnt    = sel ? 2'b10 : 2'b01;
                m0_err = !sel & own_stb;
                m1_err = sel & own_stb;
                if (!own_cyc) begin
                    state_nxt = ST_IDLE;
                    last_nxt  = sel;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_arb2.sv
// tb/tb_wb_arb2.sv - self-checking bench for wb_arb2
module tb_wb_arb2;

    localparam int ADRBITS   = 1;
    localparam int TMOBITS   = 4;
    localparam int TMO_LIMIT = 1 << TMOBITS;

    logic        wb_clk = 1'b0;
    logic        wb_rst_n;
    logic [1:0]  cyc, stb, we;
    logic [ADRBITS-1:0] adr [2];
    logic [15:0] wdat [2];
    logic [15:0] s_dat_i;
    logic        s_ack;

    logic [15:0] m0_dat_o, m1_dat_o, s_dat_o;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic        s_cyc, s_stb, s_we;
    logic [ADRBITS-1:0] s_adr;
    logic [1:0]  gnt;

    wb_arb2 #(
        .ADRBITS(ADRBITS),
        .TMOBITS(TMOBITS)
    ) dut (
        .wb_clk  (wb_clk),
        .wb_rst_n(wb_rst_n),
        .m0_cyc  (cyc[0]),
        .m0_stb  (stb[0]),
        .m0_we   (we[0]),
        .m0_adr  (adr[0]),
        .m0_dat_i(wdat[0]),
        .m0_dat_o(m0_dat_o),
        .m0_ack  (m0_ack),
        .m0_err  (m0_err),
        .m1_cyc  (cyc[1]),
        .m1_stb  (stb[1]),
        .m1_we   (we[1]),
        .m1_adr  (adr[1]),
        .m1_dat_i(wdat[1]),
        .m1_dat_o(m1_dat_o),
        .m1_ack  (m1_ack),
        .m1_err  (m1_err),
        .s_cyc   (s_cyc),
        .s_stb   (s_stb),
        .s_we    (s_we),
        .s_adr   (s_adr),
        .s_dat_o (s_dat_o),
        .s_dat_i (s_dat_i),
        .s_ack   (s_ack),
        .gnt     (gnt)
    );

    always #5 wb_clk = ~wb_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: who owns the bus, whether the grant was aborted,
    // how many consecutive wait cycles have elapsed, who was served last.
    int owner;
    int last;
    int waits;
    bit aborted;

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner   = -1;
        last    = 1;
        waits   = 0;
        aborted = 0;
    endtask

    task automatic check_outputs();
        logic [1:0]  e_gnt, e_ack, e_err;
        logic [19:0] e_bus;
        e_gnt = 2'b00;
        e_ack = 2'b00;
        e_err = 2'b00;
        e_bus = '0;
        if (owner >= 0) begin
            e_gnt[owner] = 1'b1;
            if (aborted) begin
                e_err[owner] = stb[owner];
            end else begin
                e_bus = {cyc[owner], stb[owner], we[owner], adr[owner], wdat[owner]};
                e_ack[owner] = s_ack;
            end
        end
        check("gnt", 40'(gnt), 40'(e_gnt));
        check("s_bus", 40'({s_cyc, s_stb, s_we, s_adr, s_dat_o}), 40'(e_bus));
        check("ack", 40'({m1_ack, m0_ack}), 40'(e_ack));
        check("err", 40'({m1_err, m0_err}), 40'(e_err));
        check("dat_o", 40'({m1_dat_o, m0_dat_o}), 40'({s_dat_i, s_dat_i}));
    endtask

    task automatic model_step();
        bit r0, r1;
        r0 = cyc[0] & stb[0];
        r1 = cyc[1] & stb[1];
        if (owner < 0) begin
            if (r0 && r1) owner = (last == 0) ? 1 : 0;
            else if (r0)  owner = 0;
            else if (r1)  owner = 1;
            waits   = 0;
            aborted = 0;
        end else if (!cyc[owner]) begin
            last    = owner;
            owner   = -1;
            aborted = 0;
        end else if (!aborted) begin
            if (stb[owner] && !s_ack) begin
                waits++;
                if (waits == TMO_LIMIT) aborted = 1;
            end else begin
                waits = 0;
            end
        end
    endtask

    // One clock: compare mid-cycle, advance the model, return just after the edge.
    task automatic tick();
        @(negedge wb_clk);
        check_outputs();
        model_step();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic pulse_reset();
        wb_rst_n = 1'b0;
        #1;
        check("rst_gnt", 40'(gnt), 40'd0);
        check("rst_s_cyc", 40'(s_cyc), 40'd0);
        check("rst_term", 40'({m1_ack, m0_ack, m1_err, m0_err}), 40'd0);
        wb_rst_n = 1'b1;
        model_reset();
    endtask

    task automatic idle_all();
        cyc = 2'b00;
        stb = 2'b00;
        s_ack = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int g, e, mode;
        cyc = 2'b00; stb = 2'b00; we = 2'b00;
        adr[0] = '0; adr[1] = '0; wdat[0] = '0; wdat[1] = '0;
        s_dat_i = 16'h0; s_ack = 1'b0;
        wb_rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge wb_clk);
        #1;
        check("reset_gnt", 40'(gnt), 40'd0);
        check("reset_s_bus", 40'({s_cyc, s_stb, s_we, s_adr, s_dat_o}), 40'd0);
        check("reset_term", 40'({m1_ack, m0_ack, m1_err, m0_err}), 40'd0);
        wb_rst_n = 1'b1;
        tick();

        // Single master write with a registered-ack slave.
        cyc[0] = 1; stb[0] = 1; we[0] = 1; adr[0] = '0; wdat[0] = 16'hA5C3;
        tick();
        check("wr_gnt", 40'(gnt), 40'd1);
        check("wr_slave", 40'({s_we, s_dat_o}), 40'({1'b1, 16'hA5C3}));
        s_ack = 1; #1;
        check("wr_ack", 40'({m1_ack, m0_ack}), 40'b01);
        tick();
        idle_all();

        // Contention from reset: m0 first, bubble, then m1, then m0 again.
        wb_rst_n = 1'b0; #1; wb_rst_n = 1'b1; model_reset();
        cyc = 2'b11; stb = 2'b11; we = 2'b00;
        tick();
        check("cont_first", 40'(gnt), 40'b01);
        cyc[0] = 0; stb[0] = 0;
        tick();
        check("cont_bubble", 40'(gnt), 40'b00);
        tick();
        check("cont_second", 40'(gnt), 40'b10);
        cyc[1] = 0; stb[1] = 0;
        tick();
        cyc = 2'b11; stb = 2'b11;
        tick();
        check("cont_third", 40'(gnt), 40'b01);
        idle_all();

        // Held burst: m1 does three reads while m0 waits.
        cyc[1] = 1; stb[1] = 1; we[1] = 0;
        tick();
        cyc[0] = 1; stb[0] = 1;
        for (int i = 0; i < 3; i++) begin
            s_dat_i = 16'($urandom);
            s_ack = 1; #1;
            check("burst_ack", 40'({m1_ack, m0_ack}), 40'b10);
            check("burst_dat", 40'(m1_dat_o), 40'(s_dat_i));
            tick();
            s_ack = 0;
            tick();
            check("burst_hold", 40'(gnt), 40'b10);
        end
        cyc[1] = 0; stb[1] = 0;
        tick();
        tick();
        check("burst_next", 40'(gnt), 40'b01);
        idle_all();

        // Watchdog timeout with a slave that never acknowledges.
        cyc[0] = 1; stb[0] = 1; s_ack = 0;
        g = -1; e = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (g < 0 && gnt == 2'b01) g = i;
            if (e < 0 && m0_err) begin
                e = i;
                check("tmo_s_cyc", 40'(s_cyc), 40'd0);
            end
        end
        check("tmo_latency", 40'(e - g), 40'(TMO_LIMIT));
        cyc[0] = 0; stb[0] = 0; cyc[1] = 1; stb[1] = 1;
        tick();
        tick();
        check("tmo_regrant", 40'(gnt), 40'b10);
        idle_all();

        // Ack arriving on the terminal-count cycle wins over the abort.
        cyc[0] = 1; stb[0] = 1;
        tick();
        repeat (TMO_LIMIT - 1) tick();
        s_ack = 1; #1;
        check("tc_ack", 40'({m0_err, m0_ack}), 40'b01);
        tick();
        s_ack = 0; #1;
        check("tc_no_abort", 40'({gnt, m0_err}), 40'b010);
        idle_all();

        // Reset mid-write during GNT1.
        cyc[1] = 1; stb[1] = 1; we[1] = 1;
        tick();
        s_ack = 1; #1;
        check("mid_ack", 40'(m1_ack), 40'd1);
        pulse_reset();
        s_ack = 0; cyc = 2'b11; stb = 2'b11;
        tick();
        check("post_rst_gnt", 40'(gnt), 40'b01);
        idle_all();

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            mode = (i / 200) % 3;
            for (int m = 0; m < 2; m++) begin
                if (cyc[m]) begin
                    if ($urandom_range(0, (mode == 1) ? 39 : 7) == 0) cyc[m] = 0;
                end else if ($urandom_range(0, 3) == 0) begin
                    cyc[m] = 1;
                end
                if (mode == 1) stb[m] = cyc[m];
                else stb[m] = cyc[m] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
                we[m]   = 1'($urandom);
                adr[m]  = ADRBITS'($urandom);
                wdat[m] = 16'($urandom);
            end
            case (mode)
                0:       s_ack = 1'($urandom);
                1:       s_ack = 1'b0;
                default: s_ack = ($urandom_range(0, 19) == 0);
            endcase
            s_dat_i = 16'($urandom);
            if (owner >= 0 && $urandom_range(0, 149) == 0) pulse_reset();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
